// File: rtl/bypass_reg_file_pkg.sv
// Shared processor constants: datapath width, register-address width and the
// register-file defaults derived from them.
package bypass_reg_file_pkg;

    localparam int DATA_W     = 16;
    localparam int REG_ADDR_W = 3;

    localparam int RF_W = DATA_W;
    localparam int RF_N = REG_ADDR_W;

endpackage

// File: rtl/bypass_reg_file_if.sv
// Register-file bus: two write ports, two read ports, issue strobe and flush.
// The master drives requests; the slave (the register file) returns read data.
interface bypass_reg_file_if import bypass_reg_file_pkg::*; #(
    parameter int W = RF_W,
    parameter int N = RF_N
);

    logic         we0;
    logic         we1;
    logic [N-1:0] wa0;
    logic [N-1:0] wa1;
    logic [W-1:0] wd0;
    logic [W-1:0] wd1;
    logic [N-1:0] ra0;
    logic [N-1:0] ra1;
    logic [W-1:0] rd0;
    logic [W-1:0] rd1;
    logic         rdy0;
    logic         rdy1;
    logic         iss_v;
    logic [N-1:0] iss_dst;
    logic         flush;
    logic [N:0]   pend_cnt;

    modport master (
        output we0, we1, wa0, wa1, wd0, wd1, ra0, ra1, iss_v, iss_dst, flush,
        input  rd0, rd1, rdy0, rdy1, pend_cnt
    );

    modport slave (
        input  we0, we1, wa0, wa1, wd0, wd1, ra0, ra1, iss_v, iss_dst, flush,
        output rd0, rd1, rdy0, rdy1, pend_cnt
    );

endinterface

// File: rtl/bypass_reg_file_scoreboard.sv
// rf_scoreboard: one pending bit per register, set by issue and cleared by
// writes, with flush clearing everything; pend_cnt is the live population count.
module rf_scoreboard import bypass_reg_file_pkg::*; #(
    parameter int N = RF_N
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we0,
    input  logic [N-1:0]        wa0,
    input  logic                we1,
    input  logic [N-1:0]        wa1,
    input  logic                iss_v,
    input  logic [N-1:0]        iss_dst,
    input  logic                flush,
    output logic [(1<<N)-1:0]   pending,
    output logic [N:0]          pend_cnt
);

    localparam int DEPTH = 1 << N;

    logic [DEPTH-1:0] pending_next;

    // Ordering encodes priority: an issue beats a same-cycle write, flush beats all.
    always_comb begin
        pending_next = pending;
        if (we0)   pending_next[wa0]     = 1'b0;
        if (we1)   pending_next[wa1]     = 1'b0;
        if (iss_v) pending_next[iss_dst] = 1'b1;
        if (flush) pending_next          = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pending <= '0;
        else      pending <= pending_next;
    end

    always_comb begin
        pend_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pend_cnt = pend_cnt + (N+1)'(pending[i]);
        end
    end

endmodule

// File: rtl/bypass_reg_file.sv
// Two-write/two-read register file with write-through bypass and an
// issue-tracking scoreboard that flags operands still awaiting a write.
module bypass_reg_file import bypass_reg_file_pkg::*; #(
    parameter int W = RF_W,
    parameter int N = RF_N
) (
    input logic              clk,
    input logic              rst,
    bypass_reg_file_if.slave bus
);

    localparam int DEPTH = 1 << N;

    logic [W-1:0]     regs [DEPTH];
    logic [DEPTH-1:0] pending;
    logic [N:0]       pend_cnt;
    logic [W-1:0]     rd0;
    logic [W-1:0]     rd1;
    logic             hit0;
    logic             hit1;

    rf_scoreboard #(.N(N)) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .we0      (bus.we0),
        .wa0      (bus.wa0),
        .we1      (bus.we1),
        .wa1      (bus.wa1),
        .iss_v    (bus.iss_v),
        .iss_dst  (bus.iss_dst),
        .flush    (bus.flush),
        .pending  (pending),
        .pend_cnt (pend_cnt)
    );

    // Port 1 is written last so it wins an address collision with port 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            if (bus.we0) regs[bus.wa0] <= bus.wd0;
            if (bus.we1) regs[bus.wa1] <= bus.wd1;
        end
    end

    always_comb begin
        rd0  = regs[bus.ra0];
        hit0 = 1'b0;
        if (bus.we0 && bus.wa0 == bus.ra0) begin
            rd0  = bus.wd0;
            hit0 = 1'b1;
        end
        if (bus.we1 && bus.wa1 == bus.ra0) begin
            rd0  = bus.wd1;
            hit0 = 1'b1;
        end
    end

    always_comb begin
        rd1  = regs[bus.ra1];
        hit1 = 1'b0;
        if (bus.we0 && bus.wa0 == bus.ra1) begin
            rd1  = bus.wd0;
            hit1 = 1'b1;
        end
        if (bus.we1 && bus.wa1 == bus.ra1) begin
            rd1  = bus.wd1;
            hit1 = 1'b1;
        end
    end

    assign bus.rd0      = rd0;
    assign bus.rd1      = rd1;
    assign bus.rdy0     = !pending[bus.ra0] || hit0;
    assign bus.rdy1     = !pending[bus.ra1] || hit1;
    assign bus.pend_cnt = pend_cnt;

endmodule
